axi4_dwch_sender: RTL and testbench

AXI4_DWCH_SENDER -- requirements
Module: axi4_dwch_sender

---
 rtl/axi4_dwch_sender.sv | 114 +++++++++++
 tb/tb_axi4_dwch_sender.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_dwch_sender.sv
// AXI4 W-channel sender: forwards or discards each W burst according to
// a queue of AW translation decisions, one decision per burst.
module axi4_dwch_sender #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_USER_WIDTH = 2,
    parameter int C_DEPTH          = 4
) (
    input  logic                          axi4_aclk,
    input  logic                          axi4_arst,
    input  logic                          trans_valid,
    input  logic                          trans_drop,
    output logic                          trans_ready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
    input  logic                          s_axi4_wlast,
    input  logic [C_AXI_USER_WIDTH-1:0]   s_axi4_wuser,
    input  logic                          s_axi4_wvalid,
    output logic                          s_axi4_wready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
    output logic                          m_axi4_wlast,
    output logic [C_AXI_USER_WIDTH-1:0]   m_axi4_wuser,
    output logic                          m_axi4_wvalid,
    input  logic                          m_axi4_wready,
    output logic                          wdrop_done
);

    localparam int PW = $clog2(C_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    logic [C_DEPTH-1:0] drop_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [PW:0]      count;
    logic             push;
    logic             burst_end;
    logic             head_drop;
    logic             next_drop;
    logic             more;

    // Full is judged on the registered count only, so a pop never frees a
    // slot for a push in the same cycle.
    assign trans_ready = (count != (PW+1)'(C_DEPTH));
    assign push        = trans_valid && trans_ready;
    assign burst_end   = s_axi4_wvalid && s_axi4_wready && s_axi4_wlast;
    assign rd_nxt      = rd_ptr + PW'(1);
    assign head_drop   = drop_mem[rd_ptr];
    assign next_drop   = drop_mem[rd_nxt];
    assign more        = (count > (PW+1)'(1));

    assign s_axi4_wready = (state == DROP) ||
                           ((state == FWD) && m_axi4_wready);
    assign m_axi4_wvalid = (state == FWD) && s_axi4_wvalid;
    assign m_axi4_wdata  = s_axi4_wdata;
    assign m_axi4_wstrb  = s_axi4_wstrb;
    assign m_axi4_wlast  = s_axi4_wlast;
    assign m_axi4_wuser  = s_axi4_wuser;

    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            drop_mem[wr_ptr] <= trans_drop;
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wdrop_done <= 1'b0;
        end else begin
            wdrop_done <= burst_end && (state == DROP);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (burst_end) begin
                rd_ptr <= rd_nxt;
            end
            unique case ({push, burst_end})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // At a burst end the following entry, if already queued,
            // selects the next mode directly so bursts stream back to back.
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= head_drop ? DROP : FWD;
                    end
                end
                FWD, DROP: begin
                    if (burst_end) begin
                        if (!more) begin
                            state <= IDLE;
                        end else begin
                            state <= next_drop ? DROP : FWD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_dwch_sender.sv
// Bench for axi4_dwch_sender: directed scenarios plus a randomized burst
// stream, checked against a decision-queue reference model.
module tb_axi4_dwch_sender;

    localparam int DW    = 32;
    localparam int UW    = 2;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int NRAND = 40;

    logic          axi4_aclk = 1'b0;
    logic          axi4_arst = 1'b1;
    logic          trans_valid = 1'b0;
    logic          trans_drop = 1'b0;
    logic          trans_ready;
    logic [DW-1:0] s_axi4_wdata = '0;
    logic [SW-1:0] s_axi4_wstrb = '0;
    logic          s_axi4_wlast = 1'b0;
    logic [UW-1:0] s_axi4_wuser = '0;
    logic          s_axi4_wvalid = 1'b0;
    logic          s_axi4_wready;
    logic [DW-1:0] m_axi4_wdata;
    logic [SW-1:0] m_axi4_wstrb;
    logic          m_axi4_wlast;
    logic [UW-1:0] m_axi4_wuser;
    logic          m_axi4_wvalid;
    logic          m_axi4_wready = 1'b1;
    logic          wdrop_done;

    int n_tests = 0;
    int n_fail  = 0;
    int fwd_cnt = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    bit dec_q[$];
    bit exp_done = 1'b0;
    bit mpend = 1'b0;
    bit mon_d;
    bit bp_done;
    bit dec_a[NRAND];
    int len_a[NRAND];

    axi4_dwch_sender #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_USER_WIDTH(UW),
        .C_DEPTH(DEPTH)
    ) dut (
        .axi4_aclk(axi4_aclk),
        .axi4_arst(axi4_arst),
        .trans_valid(trans_valid),
        .trans_drop(trans_drop),
        .trans_ready(trans_ready),
        .s_axi4_wdata(s_axi4_wdata),
        .s_axi4_wstrb(s_axi4_wstrb),
        .s_axi4_wlast(s_axi4_wlast),
        .s_axi4_wuser(s_axi4_wuser),
        .s_axi4_wvalid(s_axi4_wvalid),
        .s_axi4_wready(s_axi4_wready),
        .m_axi4_wdata(m_axi4_wdata),
        .m_axi4_wstrb(m_axi4_wstrb),
        .m_axi4_wlast(m_axi4_wlast),
        .m_axi4_wuser(m_axi4_wuser),
        .m_axi4_wvalid(m_axi4_wvalid),
        .m_axi4_wready(m_axi4_wready),
        .wdrop_done(wdrop_done)
    );

    always #5 axi4_aclk = ~axi4_aclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge axi4_aclk) begin
        #1;
        if (rdy_mode == 0) m_axi4_wready = 1'b1;
        else if (rdy_mode == 1) m_axi4_wready = !m_axi4_wready;
        else m_axi4_wready = ($urandom_range(0, 3) != 0);
    end

    // Reference model: decisions queue in order, the k-th burst uses the
    // k-th decision, and a decision leaves the queue at its burst's last beat.
    always @(negedge axi4_aclk) begin
        if (axi4_arst) begin
            dec_q.delete();
            exp_done = 1'b0;
            mpend = 1'b0;
        end else begin
            check("trans_ready", 64'(trans_ready), 64'(dec_q.size() < DEPTH));
            check("wdrop_done", 64'(wdrop_done), 64'(exp_done));
            if (wdrop_done) done_cnt++;
            exp_done = 1'b0;
            if (mpend) check("wvalid_hold", 64'(m_axi4_wvalid), 64'(1));
            mpend = m_axi4_wvalid && !m_axi4_wready;
            if (dec_q.size() == 0) begin
                check("idle_sready", 64'(s_axi4_wready), 64'(0));
                check("idle_mvalid", 64'(m_axi4_wvalid), 64'(0));
            end else if (s_axi4_wvalid && s_axi4_wready) begin
                mon_d = dec_q[0];
                if (mon_d) begin
                    check("drop_mvalid", 64'(m_axi4_wvalid), 64'(0));
                end else begin
                    check("fwd_hs", 64'(m_axi4_wvalid && m_axi4_wready),
                          64'(1));
                    check("fwd_beat",
                          64'({m_axi4_wdata, m_axi4_wstrb,
                               m_axi4_wlast, m_axi4_wuser}),
                          64'({s_axi4_wdata, s_axi4_wstrb,
                               s_axi4_wlast, s_axi4_wuser}));
                    fwd_cnt++;
                end
                if (s_axi4_wlast) begin
                    void'(dec_q.pop_front());
                    exp_done = mon_d;
                end
            end else begin
                check("m_hs_alone", 64'(m_axi4_wvalid && m_axi4_wready),
                      64'(0));
            end
            if (trans_valid && trans_ready) dec_q.push_back(trans_drop);
        end
    end

    task automatic send_dec(input bit d);
        bit acc;
        acc = 1'b0;
        trans_valid = 1'b1;
        trans_drop = d;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge axi4_aclk);
            acc = trans_ready;
        end
        check("dec_accept", 64'(acc), 64'(1));
        @(posedge axi4_aclk);
        #1;
        trans_valid = 1'b0;
    endtask

    task automatic send_burst(input int len, input bit last_en,
                              input int gap_max, output int stalls);
        bit acc;
        int g;
        stalls = 0;
        for (int b = 0; b < len; b++) begin
            g = int'($urandom_range(0, gap_max));
            repeat (g) begin
                @(posedge axi4_aclk);
                #1;
            end
            s_axi4_wvalid = 1'b1;
            s_axi4_wdata = $urandom;
            s_axi4_wstrb = SW'($urandom);
            s_axi4_wuser = UW'($urandom);
            s_axi4_wlast = last_en && (b == len - 1);
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge axi4_aclk);
                acc = s_axi4_wready;
                if (!acc) stalls++;
            end
            check("beat_accept", 64'(acc), 64'(1));
            @(posedge axi4_aclk);
            #1;
            s_axi4_wvalid = 1'b0;
            s_axi4_wlast = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        int f0;
        int d0;
        int exp_fwd;
        int exp_drops;

        repeat (3) @(posedge axi4_aclk);
        @(negedge axi4_aclk);
        check("rst_mvalid", 64'(m_axi4_wvalid), 64'(0));
        check("rst_sready", 64'(s_axi4_wready), 64'(0));
        check("rst_tready", 64'(trans_ready), 64'(1));
        check("rst_done", 64'(wdrop_done), 64'(0));
        @(posedge axi4_aclk);
        #1;
        axi4_arst = 1'b0;

        // Forward burst, including the one-cycle decision latency.
        send_dec(1'b0);
        @(negedge axi4_aclk);
        check("push_latency", 64'(s_axi4_wready), 64'(0));
        @(posedge axi4_aclk);
        #1;
        f0 = fwd_cnt;
        send_burst(4, 1'b1, 0, st);
        check("fwd_stalls", 64'(st), 64'(0));
        check("fwd_beats", 64'(fwd_cnt - f0), 64'(4));
        @(negedge axi4_aclk);
        check("fwd_idle_after", 64'(s_axi4_wready), 64'(0));
        @(posedge axi4_aclk);
        #1;

        // Dropped burst.
        send_dec(1'b1);
        @(posedge axi4_aclk);
        #1;
        send_burst(2, 1'b1, 0, st);
        check("drop_stalls", 64'(st), 64'(0));
        @(negedge axi4_aclk);
        check("drop_pulse", 64'(wdrop_done), 64'(1));
        @(posedge axi4_aclk);
        #1;
        @(negedge axi4_aclk);
        check("drop_pulse_end", 64'(wdrop_done), 64'(0));
        @(posedge axi4_aclk);
        #1;

        // Back-to-back fwd/drop/fwd with no bubble.
        send_dec(1'b0);
        send_dec(1'b1);
        send_dec(1'b0);
        f0 = fwd_cnt;
        for (int i = 0; i < 3; i++) begin
            send_burst(1, 1'b1, 0, st);
            check("b2b_stall", 64'(st), 64'(0));
        end
        check("b2b_fwd", 64'(fwd_cnt - f0), 64'(2));
        repeat (2) @(posedge axi4_aclk);
        #1;

        // Full FIFO, held fifth decision, pop and push in the same cycle.
        for (int i = 0; i < 4; i++) send_dec(1'b0);
        trans_valid = 1'b1;
        trans_drop = 1'b1;
        @(negedge axi4_aclk);
        check("full_ready", 64'(trans_ready), 64'(0));
        @(posedge axi4_aclk);
        #1;
        s_axi4_wvalid = 1'b1;
        s_axi4_wlast = 1'b1;
        s_axi4_wdata = $urandom;
        @(negedge axi4_aclk);
        check("pop_sready", 64'(s_axi4_wready), 64'(1));
        check("pop_push_same", 64'(trans_ready), 64'(0));
        @(posedge axi4_aclk);
        #1;
        s_axi4_wvalid = 1'b0;
        s_axi4_wlast = 1'b0;
        @(negedge axi4_aclk);
        check("after_pop_ready", 64'(trans_ready), 64'(1));
        @(posedge axi4_aclk);
        #1;
        trans_valid = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_burst(1, 1'b1, 1, st);
        repeat (2) @(posedge axi4_aclk);
        #1;
        check("full_drain_drops", 64'(done_cnt - d0), 64'(1));

        // Backpressure: wready toggles, s_wready must follow it.
        rdy_mode = 1;
        send_dec(1'b0);
        @(posedge axi4_aclk);
        #1;
        f0 = fwd_cnt;
        bp_done = 1'b0;
        fork
            begin
                send_burst(4, 1'b1, 0, st);
                bp_done = 1'b1;
            end
            begin
                for (int t = 0; t < 60 && !bp_done; t++) begin
                    @(negedge axi4_aclk);
                    if (!bp_done)
                        check("bp_mirror", 64'(s_axi4_wready),
                              64'(m_axi4_wready));
                end
            end
        join
        check("bp_beats", 64'(fwd_cnt - f0), 64'(4));
        rdy_mode = 0;
        repeat (2) @(posedge axi4_aclk);
        #1;

        // Reset in the middle of a forwarded burst.
        send_dec(1'b0);
        send_dec(1'b1);
        send_burst(2, 1'b0, 0, st);
        axi4_arst = 1'b1;
        @(posedge axi4_aclk);
        #1;
        axi4_arst = 1'b0;
        @(negedge axi4_aclk);
        check("mid_rst_mvalid", 64'(m_axi4_wvalid), 64'(0));
        check("mid_rst_sready", 64'(s_axi4_wready), 64'(0));
        check("mid_rst_tready", 64'(trans_ready), 64'(1));
        check("mid_rst_done", 64'(wdrop_done), 64'(0));
        @(posedge axi4_aclk);
        #1;
        s_axi4_wvalid = 1'b1;
        s_axi4_wlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi4_aclk);
            check("no_dec_stall", 64'(s_axi4_wready), 64'(0));
            check("no_dec_done", 64'(wdrop_done), 64'(0));
        end
        @(posedge axi4_aclk);
        #1;
        s_axi4_wvalid = 1'b0;
        s_axi4_wlast = 1'b0;

        // Randomized stream with random ready and gaps.
        rdy_mode = 2;
        exp_fwd = 0;
        exp_drops = 0;
        for (int i = 0; i < NRAND; i++) begin
            dec_a[i] = 1'($urandom_range(0, 1));
            len_a[i] = int'($urandom_range(1, 4));
            if (dec_a[i]) exp_drops++;
            else exp_fwd += len_a[i];
        end
        f0 = fwd_cnt;
        d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    send_dec(dec_a[i]);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge axi4_aclk);
                        #1;
                    end
                end
            end
            begin
                int rs;
                for (int i = 0; i < NRAND; i++)
                    send_burst(len_a[i], 1'b1, 2, rs);
            end
        join
        repeat (3) @(posedge axi4_aclk);
        #1;
        check("rand_fwd_beats", 64'(fwd_cnt - f0), 64'(exp_fwd));
        check("rand_drops", 64'(done_cnt - d0), 64'(exp_drops));
        @(negedge axi4_aclk);
        check("rand_end_tready", 64'(trans_ready), 64'(1));
        check("rand_end_sready", 64'(s_axi4_wready), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
